// File: rtl/bram_stream_fifo_ctrl_if.sv
// rtl/bram_stream_fifo_ctrl_if.sv - byte stream and status bundle for the BRAM FIFO controller
`timescale 1ns/1ps

interface bram_stream_fifo_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   level;
  logic              almost_full;

  // Producer/consumer side of the FIFO
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, almost_full
  );

  // FIFO controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level, almost_full
  );
endinterface

// File: rtl/bram_stream_fifo_ctrl.sv
// rtl/bram_stream_fifo_ctrl.sv - stream FIFO over a 2-port BRAM with 2-entry read prefetch
`timescale 1ns/1ps

module bram_stream_fifo_ctrl #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int AFULL_THRESH = 1920
) (
  input  logic              CLK,
  input  logic              RST,
  bram_stream_fifo_ctrl_if.slave s,
  output logic [ADDR_W-1:0] mem_a0,
  output logic [DATA_W-1:0] mem_d0,
  output logic              mem_we0,
  output logic [DATA_W-1:0] mem_wem0,
  output logic              mem_ce0,
  output logic [ADDR_W-1:0] mem_a1,
  output logic [DATA_W-1:0] mem_d1,
  output logic              mem_we1,
  output logic [DATA_W-1:0] mem_wem1,
  output logic              mem_ce1,
  input  logic [DATA_W-1:0] mem_q1
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AFULL_L = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;   // bytes committed to BRAM and not yet read
  logic [ADDR_W:0]   level;
  logic              inflight;  // read issued last cycle, mem_q1 valid now
  logic [1:0]        out_cnt;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;

  logic              in_rdy;
  logic              out_vld;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [1:0]        cnt_after_pop;

  // Handshakes and prefetch decision; reads may refill the slot a pop frees this cycle
  always_comb begin
    in_rdy        = (level != DEPTH_L);
    out_vld       = (out_cnt != 2'd0);
    push          = s.in_valid && in_rdy && !RST;
    pop           = out_vld && s.out_ready && !RST;
    rd_issue      = (mem_cnt != '0) && !RST &&
                    (((out_cnt + {1'b0, inflight}) < 2'd2) || pop);
    cnt_after_pop = out_cnt - {1'b0, pop};
  end

  assign s.in_ready    = in_rdy;
  assign s.out_valid   = out_vld;
  assign s.out_data    = head_q;
  assign s.level       = level;
  assign s.almost_full = (level >= AFULL_L);

  assign mem_ce0  = push;
  assign mem_we0  = push;
  assign mem_a0   = wr_ptr;
  assign mem_d0   = s.in_data;
  assign mem_wem0 = '1;

  assign mem_ce1  = rd_issue;
  assign mem_a1   = rd_ptr;
  assign mem_we1  = 1'b0;
  assign mem_d1   = '0;
  assign mem_wem1 = '0;

  // Pointers and occupancy counters; level stays equal to mem_cnt + inflight + out_cnt
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      level    <= '0;
      inflight <= 1'b0;
      out_cnt  <= 2'd0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      mem_cnt  <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd_issue);
      level    <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      inflight <= rd_issue;
      out_cnt  <= cnt_after_pop + {1'b0, inflight};
    end
  end

  // Output buffer: pop shifts tail to head, returning read data lands in the first free slot
  always_ff @(posedge CLK) begin
    if (pop) head_q <= tail_q;
    if (inflight && !RST) begin
      if (cnt_after_pop == 2'd0) head_q <= mem_q1;
      else                       tail_q <= mem_q1;
    end
  end
endmodule

// File: tb/tb_bram_stream_fifo_ctrl.sv
// tb/tb_bram_stream_fifo_ctrl.sv - bench for the BRAM stream FIFO controller
`timescale 1ns/1ps

module tb_bram_stream_fifo_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [10:0] mem_a0, mem_a1;
  logic [7:0]  mem_d0, mem_d1, mem_wem0, mem_wem1, mem_q1;
  logic        mem_we0, mem_ce0, mem_we1, mem_ce1;
  logic [7:0]  bram [2048];

  bram_stream_fifo_ctrl_if #(.ADDR_W(11), .DATA_W(8)) bus ();

  bram_stream_fifo_ctrl #(.ADDR_W(11), .DATA_W(8), .AFULL_THRESH(1920)) dut (
    .CLK(CLK), .RST(RST), .s(bus),
    .mem_a0(mem_a0), .mem_d0(mem_d0), .mem_we0(mem_we0), .mem_wem0(mem_wem0), .mem_ce0(mem_ce0),
    .mem_a1(mem_a1), .mem_d1(mem_d1), .mem_we1(mem_we1), .mem_wem1(mem_wem1), .mem_ce1(mem_ce1),
    .mem_q1(mem_q1)
  );

  always #5 CLK = ~CLK;

  // BRAM_2048x8 model: write port 0, registered read port 1
  always @(posedge CLK) begin
    if (mem_ce0 && mem_we0) bram[mem_a0] <= mem_d0;
    if (mem_ce1) mem_q1 <= bram[mem_a1];
  end

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        x_ir;
    logic        x_ov;
    logic [7:0]  x_od;
    logic [11:0] x_lvl;
    logic        x_ce0;
    logic [10:0] x_a0;
    logic        x_ce1;
    logic [10:0] x_a1;
  } vec_t;

  vec_t        tbl [12];
  int          n_err = 0;
  int          n_checks = 0;
  logic [7:0]  q [$];
  logic [10:0] wr_model = '0;
  logic        hold_pending = 1'b0;
  logic [7:0]  held = '0;
  int          max_lvl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    q.delete();
    wr_model = '0;
    hold_pending = 1'b0;
  endtask

  // One clock cycle with scoreboard checks against a reference queue
  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
    logic acc, pp;
    @(negedge CLK);
    bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    #1;
    chk("sb_level", 32'(bus.level), q.size());
    chk("sb_in_ready", 32'(bus.in_ready), 32'(q.size() != 2048));
    chk("sb_almost_full", 32'(bus.almost_full), 32'(q.size() >= 1920));
    if (hold_pending) chk("sb_hold", 32'(bus.out_data), 32'(held));
    if (bus.out_valid && q.size() == 0) chk("sb_valid_empty", 32'(bus.out_valid), 0);
    if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    acc = iv && bus.in_ready;
    pp  = bus.out_valid && ordy;
    chk("sb_ce0", 32'(mem_ce0 && mem_we0), 32'(acc));
    if (acc) begin
      chk("sb_a0", 32'(mem_a0), 32'(wr_model));
      chk("sb_d0", 32'(mem_d0), 32'(d));
    end
    if (pp && q.size() != 0) begin
      chk("sb_data", 32'(bus.out_data), 32'(q[0]));
      void'(q.pop_front());
    end
    if (acc) begin
      q.push_back(d);
      wr_model = wr_model + 11'd1;
    end
    hold_pending = bus.out_valid && !ordy;
    held = bus.out_data;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2200 && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk(name, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    //         iv  d      or   ir   ov   od     lvl  ce0  a0  ce1  a1
    tbl[0]  = '{1, 8'hA5, 0,   1,   0,   8'h00, 0,   1,   0,  0,   0};
    tbl[1]  = '{0, 8'h00, 0,   1,   0,   8'h00, 1,   0,   0,  1,   0};
    tbl[2]  = '{0, 8'h00, 0,   1,   0,   8'h00, 1,   0,   0,  0,   0};
    tbl[3]  = '{0, 8'h00, 1,   1,   1,   8'hA5, 1,   0,   0,  0,   0};
    tbl[4]  = '{1, 8'h11, 1,   1,   0,   8'h00, 0,   1,   1,  0,   0};
    tbl[5]  = '{1, 8'h22, 1,   1,   0,   8'h00, 1,   1,   2,  1,   1};
    tbl[6]  = '{1, 8'h33, 0,   1,   0,   8'h00, 2,   1,   3,  1,   2};
    tbl[7]  = '{0, 8'h00, 0,   1,   1,   8'h11, 3,   0,   0,  0,   0};
    tbl[8]  = '{0, 8'h00, 1,   1,   1,   8'h11, 3,   0,   0,  1,   3};
    tbl[9]  = '{0, 8'h00, 1,   1,   1,   8'h22, 2,   0,   0,  0,   0};
    tbl[10] = '{0, 8'h00, 1,   1,   1,   8'h33, 1,   0,   0,  0,   0};
    tbl[11] = '{0, 8'h00, 0,   1,   0,   8'h00, 0,   0,   0,  0,   0};

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    do_reset();

    // Reset state
    @(negedge CLK); #1;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_almost_full", 32'(bus.almost_full), 0);
    chk("rst_ce0", 32'(mem_ce0 | mem_we0), 0);
    chk("rst_ce1", 32'(mem_ce1), 0);
    chk("port_wem0", 32'(mem_wem0), 32'hFF);
    chk("port1_static", 32'({mem_we1, mem_d1, mem_wem1}), 0);

    // Single byte and short burst, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      bus.in_valid = tbl[i].iv; bus.in_data = tbl[i].d; bus.out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].x_ir));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].x_ov));
      if (tbl[i].x_ov) chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].x_od));
      chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(tbl[i].x_lvl));
      chk($sformatf("v%0d_ce0", i), 32'(mem_ce0 && mem_we0), 32'(tbl[i].x_ce0));
      if (tbl[i].x_ce0) chk($sformatf("v%0d_a0", i), 32'(mem_a0), 32'(tbl[i].x_a0));
      chk($sformatf("v%0d_ce1", i), 32'(mem_ce1), 32'(tbl[i].x_ce1));
      if (tbl[i].x_ce1) chk($sformatf("v%0d_a1", i), 32'(mem_a1), 32'(tbl[i].x_a1));
    end

    // Streaming 256 bytes with the consumer always ready
    do_reset();
    max_lvl = 0;
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b1);
    drain("stream_drain");
    chk("stream_max_level_le3", 32'(max_lvl <= 3), 1);

    // Fill to full (write pointer starts at 256 so it wraps), overflow, push+pop at full
    for (int i = 0; i < 2048; i++) cyc(1'b1, 8'(i) ^ 8'h5A, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("full_level", 32'(bus.level), 2048);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    chk("full_almost_full", 32'(bus.almost_full), 1);
    cyc(1'b1, 8'h77, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("full_pop_level", 32'(bus.level), 2047);
    chk("full_pop_in_ready", 32'(bus.in_ready), 1);
    drain("fill_drain");
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i) + 8'h80, 1'b0);
    drain("refill_drain");

    // Random backpressure on both sides
    for (int i = 0; i < 600; i++) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    drain("bp_drain");

    // Reset mid-stream with a read in flight
    for (int i = 0; i < 500; i++) cyc(1'b1, 8'(i) ^ 8'hC3, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("mid_level", 32'(bus.level), 500);
    chk("mid_read_issue", 32'(mem_ce1), 1);
    @(negedge CLK);
    RST = 1'b1; bus.out_ready = 1'b0;
    @(posedge CLK); #1;
    chk("mid_rst_level", 32'(bus.level), 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge CLK);
    RST = 1'b0;
    q.delete(); wr_model = '0; hold_pending = 1'b0;
    cyc(1'b1, 8'h3C, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mid_new_valid", 32'(seen), 1);
    chk("mid_first_byte", 32'(bus.out_data), 32'h3C);
    drain("mid_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
